ptw_mem_responder: RTL

- Memory-side responder for the Sv39 page-table walker's PTE read port: services walker reads (ren/addr) and returns rdata with the mmu_stall handshake.
- Contains a small direct-mapped PTE cache; misses go out on a req/gnt/rvalid memory port.
- Sits between the MMU walker and the data-memory/bus arbiter.

---
 rtl/ptw_mem_responder.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/ptw_mem_responder.sv
// ---------------------------------------------------------------------------
// ptw_mem_responder
//
// Memory-side responder for the Sv39 page-table walker's PTE read port.
// Walker reads (ren/addr) are answered from a small direct-mapped PTE cache
// when possible; misses are fetched over a req/gnt/rvalid memory port with a
// single transaction outstanding. The walker is held off with mmu_stall until
// the one-cycle RESP state, in which rdata (and fault) are valid.
//
// Ports:
//   clk, rst        clock; synchronous active-low reset
//   ren, addr       walker read request and PTE physical address
//   rdata           PTE data, valid in the cycle mmu_stall=0 with ren=1
//   mmu_stall       high while the current walker read is unanswered
//   flush           invalidate all cache lines, abort the current request
//   fault           one-cycle pulse in RESP on misalignment / memory error
//   mem_req         memory read request (held until mem_gnt)
//   mem_addr        8-byte aligned memory read address
//   mem_gnt         request accepted this cycle
//   mem_rvalid      read data returned this cycle
//   mem_rdata       read data
//   mem_err         access error, qualified by mem_rvalid
// ---------------------------------------------------------------------------
module ptw_mem_responder #(
  parameter int unsigned CACHE_ENTRIES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ren,
  input  logic [63:0] addr,
  output logic [63:0] rdata,
  output logic        mmu_stall,
  input  logic        flush,
  output logic        fault,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata,
  input  logic        mem_err
);

  localparam int unsigned IDX   = $clog2(CACHE_ENTRIES);
  localparam int unsigned TAG_W = 64 - IDX - 3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_RESP  = 3'd3,
    S_DRAIN = 3'd4
  } state_e;

  state_e                   state_q, state_d;
  logic [63:0]              rdata_q, rdata_d;
  logic                     fault_q, fault_d;
  logic                     mem_req_q, mem_req_d;
  logic [63:0]              mem_addr_q, mem_addr_d;
  logic [CACHE_ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]         tag_q  [CACHE_ENTRIES];
  logic [TAG_W-1:0]         tag_d  [CACHE_ENTRIES];
  logic [63:0]              data_q [CACHE_ENTRIES];
  logic [63:0]              data_d [CACHE_ENTRIES];

  logic [IDX-1:0]   req_idx_s;
  logic [TAG_W-1:0] req_tag_s;
  logic [IDX-1:0]   fill_idx_s;
  logic [TAG_W-1:0] fill_tag_s;
  logic             misaligned_s;
  logic             hit_s;
  logic             fill_s;

  assign req_idx_s    = addr[IDX+2:3];
  assign req_tag_s    = addr[63:IDX+3];
  assign fill_idx_s   = mem_addr_q[IDX+2:3];
  assign fill_tag_s   = mem_addr_q[63:IDX+3];
  assign misaligned_s = (addr[2:0] != 3'b000);
  // A flush in the same cycle invalidates the line, so it must not be served.
  assign hit_s        = valid_q[req_idx_s] && (tag_q[req_idx_s] == req_tag_s) && !flush;

  assign mmu_stall = ren && (state_q != S_RESP);
  assign rdata     = rdata_q;
  assign fault     = fault_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;

  // Next-state and registered-output logic of the request FSM.
  always_comb begin
    state_d    = state_q;
    rdata_d    = rdata_q;
    fault_d    = 1'b0;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    fill_s     = 1'b0;
    case (state_q)
      S_IDLE: begin
        mem_req_d = 1'b0;
        if (ren) begin
          if (misaligned_s) begin
            state_d = S_RESP;
            rdata_d = 64'd0;
            fault_d = 1'b1;
          end else if (hit_s) begin
            state_d = S_RESP;
            rdata_d = data_q[req_idx_s];
          end else begin
            state_d    = S_REQ;
            mem_req_d  = 1'b1;
            mem_addr_d = {addr[63:3], 3'b000};
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (!ren || flush) begin
          // Withdraw; a grant in this very cycle still owes us an rvalid.
          mem_req_d = 1'b0;
          state_d   = mem_gnt ? S_DRAIN : S_IDLE;
        end else if (mem_gnt) begin
          mem_req_d = 1'b0;
          state_d   = S_WAIT;
        end else begin
          mem_req_d = 1'b1;
        end
      end
      S_WAIT: begin
        mem_req_d = 1'b0;
        if (mem_rvalid) begin
          // The fill is independent of the walker; flush priority is applied in the cache update.
          fill_s = !mem_err;
          if (!ren || flush) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_RESP;
            rdata_d = mem_err ? 64'd0 : mem_rdata;
            fault_d = mem_err;
          end
        end else if (!ren || flush) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_RESP: begin
        mem_req_d = 1'b0;
        state_d   = S_IDLE;
      end
      S_DRAIN: begin
        mem_req_d = 1'b0;
        if (mem_rvalid) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        mem_req_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  // Cache line update: flush clears every valid bit and beats a concurrent fill.
  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < CACHE_ENTRIES; i++) begin
      tag_d[i]  = tag_q[i];
      data_d[i] = data_q[i];
    end
    if (flush) begin
      valid_d = '0;
    end else if (fill_s) begin
      valid_d[fill_idx_s] = 1'b1;
      tag_d[fill_idx_s]   = fill_tag_s;
      data_d[fill_idx_s]  = mem_rdata;
    end else begin
      valid_d = valid_q;
    end
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      rdata_q    <= 64'd0;
      fault_q    <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= 64'd0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      rdata_q    <= rdata_d;
      fault_q    <= fault_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      valid_q    <= valid_d;
    end
  end

  // Cache tag/data storage; contents are qualified by valid_q, so no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < CACHE_ENTRIES; i++) begin
      tag_q[i]  <= tag_d[i];
      data_q[i] <= data_d[i];
    end
  end

endmodule
